// File: rtl/ifetcher_req_tracker.sv
// Sequential instruction-fetch issuer with in-flight request tracking and jump flush.
// Define IFETCHER_REQ_ERRCHK_EN to add the sticky protocol error output oErr.
module ifetcher_req_tracker #(
    parameter int CW     = 8,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int MAXOUT = 4,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic          iClk,
    input  logic          iResetn,
    input  logic          iJumpVld,
    input  logic [AW-1:0] iJumpPc,
    input  logic          iClear,
    output logic [CW-1:0] oCounter,
    output logic          oReqVld,
    input  logic          iReqRdy,
    output logic [AW-1:0] oReqAddr,
    input  logic          iRspVld,
    input  logic [DW-1:0] iRspData,
    output logic          oInstVld,
    output logic [DW-1:0] oInstData,
    output logic [AW-1:0] oInstPc
`ifdef IFETCHER_REQ_ERRCHK_EN
    ,
    output logic          oErr
`endif
);

    localparam int PW = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAXOUT);

    typedef enum logic {
        FETCH,
        FLUSH
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   jpc_q, jpc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   fifo_q [MAXOUT];
    logic [AW-1:0]   fifo_d [MAXOUT];
    logic            inst_vld_q, inst_vld_d;
    logic [DW-1:0]   inst_data_q, inst_data_d;
    logic [AW-1:0]   inst_pc_q, inst_pc_d;

    logic            req_vld;
    logic            hs;
    logic            rsp;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAXOUT - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_vld = (state_q == FETCH) && (cnt_q < MAX_C);
    assign hs      = req_vld & iReqRdy;
    // A response with nothing outstanding belongs to no request.
    assign rsp     = iRspVld & (cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        jpc_d       = jpc_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        fifo_d      = fifo_q;
        inst_vld_d  = 1'b0;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        cnt_d       = cnt_q + CW'(hs) - CW'(rsp);

        if (hs) begin
            fifo_d[wr_q] = pc_q;
            wr_d         = ptr_inc(wr_q);
            pc_d         = pc_q + AW'(4);
        end

        if (rsp) begin
            rd_d = ptr_inc(rd_q);
            if (state_q == FETCH) begin
                inst_vld_d  = 1'b1;
                inst_data_d = iRspData;
                inst_pc_d   = fifo_q[rd_q];
            end
        end

        unique case (state_q)
            FETCH: begin
                if (iJumpVld) begin
                    jpc_d   = iJumpPc;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (iJumpVld) begin
                    jpc_d = iJumpPc;
                end else if (iClear) begin
                    state_d = FETCH;
                    pc_d    = jpc_q;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iResetn) begin
            state_q     <= FETCH;
            pc_q        <= RST_PC;
            jpc_q       <= '0;
            cnt_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            fifo_q      <= '{default: '0};
            inst_vld_q  <= 1'b0;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            jpc_q       <= jpc_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fifo_q      <= fifo_d;
            inst_vld_q  <= inst_vld_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

`ifdef IFETCHER_REQ_ERRCHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (iRspVld & (cnt_q == '0))
              | (iClear & (cnt_q != '0));
    end

    always_ff @(posedge iClk) begin
        if (!iResetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign oErr = err_q;
`endif

    assign oCounter  = cnt_q;
    assign oReqVld   = req_vld;
    assign oReqAddr  = pc_q;
    assign oInstVld  = inst_vld_q;
    assign oInstData = inst_data_q;
    assign oInstPc   = inst_pc_q;

endmodule

// File: doc/ifetcher_req_tracker.md
# ifetcher_req_tracker

Instruction-fetch request issuer and outstanding-request tracker. It issues sequential fetch requests to instruction memory and counts requests still in flight. It stops issuing on a jump and drops stale responses until the jump-reset logic pulses clear, then restarts at the jump target. It produces the outstanding counter consumed by the fetcher's jump-reset logic and consumes that logic's one-cycle clear pulse.

## Interface
- CW, 8, outstanding counter width
- AW, 32, address width
- DW, 32, instruction data width
- MAXOUT, 4, max in-flight requests; must satisfy 1 <= MAXOUT < 2^CW; also the PC FIFO depth
- RST_PC, 0, fetch address after reset

Ports:
- iClk  in  1  clock
- iResetn  in  1  reset, synchronous, active-low
- iJumpVld  in  1  redirect request, single-cycle
- iJumpPc  in  AW  redirect target, valid with iJumpVld
- iClear  in  1  one-cycle pulse; restart fetch at the held jump target
- oCounter  out  CW  registered count of outstanding requests
- oReqVld  out  1  fetch request valid
- iReqRdy  in  1  memory accepts request
- oReqAddr  out  AW  fetch address
- iRspVld  in  1  in-order response valid; never back-pressured
- iRspData  in  DW  response instruction
- oInstVld  out  1  instruction valid to decode; registered
- oInstData  out  DW  instruction
- oInstPc  out  AW  address of oInstData
- oErr  out  1  sticky protocol error; present only with IFETCHER_REQ_ERRCHK_EN

## Operation
- States:
  - FETCH: issue requests.
  - FLUSH: drain and discard.
- Reset state is FETCH.
- Internal state:
  - fetch PC register.
  - held jump PC register.
  - in-order PC FIFO, depth MAXOUT, one entry per outstanding request.
- FETCH:
  - oReqVld = (oCounter < MAXOUT); oReqAddr = fetch PC.
  - Handshake (oReqVld & iReqRdy): push fetch PC into the FIFO, fetch PC += 4 (wraps modulo 2^AW), counter +1.
- Response (iRspVld):
  - Pop the FIFO; counter -1.
  - In FETCH: next cycle oInstVld=1, oInstData=iRspData, oInstPc=popped PC.
  - In FLUSH: response discarded; oInstVld stays 0.
- Same-cycle handshake and response: counter unchanged; FIFO pushes and pops.
- iJumpVld:
  - In FETCH: held PC <= iJumpPc; state -> FLUSH next cycle. A handshake in the jump cycle still counts as outstanding, and its response is discarded.
  - In FLUSH: held PC overwritten; latest jump wins.
- FLUSH: oReqVld=0; responses only decrement.
- iClear:
  - In FLUSH: state -> FETCH, fetch PC <= held PC; first request at new PC visible the next cycle.
  - In FETCH: ignored.
  - Simultaneous iJumpVld and iClear in FLUSH: jump wins; stay in FLUSH with the new held PC.
- iRspVld while counter==0: ignored; counter stays 0; no FIFO pop; no oInstVld.
- Counter never exceeds MAXOUT; issue is blocked at MAXOUT.

## Timing
- Reset values:
  - oCounter=0, oReqVld=1 (state FETCH, counter 0), oReqAddr=RST_PC.
  - oInstVld=0, oInstData=0, oInstPc=0, oErr=0.
  - FIFO empty; held PC=0.
- Reset mid-operation discards all in-flight state; later responses for pre-reset requests are treated as counter==0 responses.
- oReqVld/oReqAddr are combinational from registered state and counter only; they do not depend on same-cycle inputs.
- oCounter updates at the edge after the handshake or response.
- Response to oInstVld latency: 1 cycle.
- Jump to oReqVld low: 1 cycle.
- iClear to new request: 1 cycle.

## Configuration
- IFETCHER_REQ_ERRCHK_EN defined:
  - oErr port exists.
  - Sets sticky on iRspVld with counter==0, or iClear while counter!=0.
  - Cleared only by reset.
- Undefined: no oErr port, no check logic; the error cases behave as described above, silently.

## Test plan
- Reset, iReqRdy=1, responses 2 cycles after each request -> addresses 0,4,8,...; oInstPc matches; oCounter settles at 2.
- iReqRdy=1, no responses -> exactly MAXOUT=4 handshakes, oCounter=4, oReqVld=0 until a response, then exactly one more request.
- 3 outstanding, iJumpVld with iJumpPc=0x100 -> oReqVld=0 next cycle; 3 responses produce no oInstVld; oCounter 3->0; iClear -> next oReqAddr=0x100.
- In FLUSH: jumps to 0x200 then 0x300, iClear and jump on the same cycle to 0x400, later iClear alone -> restart at 0x400.
- Same-cycle handshake and response at counter 2 -> counter stays 2; FIFO order preserved.
- With IFETCHER_REQ_ERRCHK_EN: iRspVld at counter 0 -> oErr=1 next cycle and stays 1; counter stays 0.
